// File: rtl/udp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : udp_pkg                                                      |
// | Description : Shared constants, state encoding and a saturating adder for |
// |               the UDP receive de-encapsulator.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package udp_pkg;

    localparam int UDP_HDR_BYTES = 8;
    localparam int UDP_PORT_W    = 16;
    localparam int UDP_LEN_W     = 16;

    // Byte offsets of the big-endian header fields (MSB first).
    localparam int UDP_SRC_OFS   = 0;
    localparam int UDP_DST_OFS   = 2;
    localparam int UDP_LEN_OFS   = 4;
    localparam int UDP_CSUM_OFS  = 6;

    // One-hot receive state.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_HDR   = 4'b0010,
        ST_PLOAD = 4'b0100,
        ST_DROP  = 4'b1000
    } udp_rx_state_e;

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [UDP_LEN_W-1:0] sat_add16(input logic [UDP_LEN_W-1:0] a,
                                                       input logic [UDP_LEN_W-1:0] b);
        logic [UDP_LEN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[UDP_LEN_W] ? {UDP_LEN_W{1'b1}} : s[UDP_LEN_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_rx_hdr_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : udp_rx_hdr_capture                                           |
// | Description : Counts header beats and assembles the 8-byte UDP header     |
// |               from DATA_W-wide beats. Field outputs already include the   |
// |               bytes of the current beat so the final header beat can be   |
// |               evaluated in the same cycle.                                 |
// | Ports       : clk, nreset  - clock, synchronous active-low reset          |
// |               i_beat       - accepted header beat                         |
// |               i_clear      - abandon a partial header (cancel / runt)     |
// |               i_data       - beat data, first byte in [7:0]               |
// |               o_hdr_done   - current beat completes the header            |
// |               o_src_port, o_dst_port, o_udp_len - header fields           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module udp_rx_hdr_capture
    import udp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  i_beat,
    input  logic                  i_clear,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_hdr_done,
    output logic [UDP_PORT_W-1:0] o_src_port,
    output logic [UDP_PORT_W-1:0] o_dst_port,
    output logic [UDP_LEN_W-1:0]  o_udp_len
);

    localparam int C_BPB       = DATA_W / 8;
    localparam int C_HDR_BEATS = UDP_HDR_BYTES / C_BPB;
    localparam int C_CNT_W     = (C_HDR_BEATS > 1) ? $clog2(C_HDR_BEATS) : 1;

    logic [C_CNT_W-1:0]         r_cnt;
    logic [8*UDP_HDR_BYTES-1:0] r_hdr;
    logic [8*UDP_HDR_BYTES-1:0] w_hdr;
    logic                       w_done;

    // Header byte b arrives on beat b/C_BPB in lane b%C_BPB.
    generate
        for (genvar b = 0; b < UDP_HDR_BYTES; b++) begin : g_byte
            localparam int C_BEAT = b / C_BPB;
            localparam int C_LANE = b % C_BPB;
            assign w_hdr[8*b +: 8] = (i_beat && (r_cnt == C_CNT_W'(C_BEAT)))
                                   ? i_data[8*C_LANE +: 8] : r_hdr[8*b +: 8];
        end
    endgenerate

    assign w_done     = i_beat && (r_cnt == C_CNT_W'(C_HDR_BEATS - 1));
    assign o_hdr_done = w_done;
    assign o_src_port = {w_hdr[8*UDP_SRC_OFS +: 8], w_hdr[8*(UDP_SRC_OFS+1) +: 8]};
    assign o_dst_port = {w_hdr[8*UDP_DST_OFS +: 8], w_hdr[8*(UDP_DST_OFS+1) +: 8]};
    assign o_udp_len  = {w_hdr[8*UDP_LEN_OFS +: 8], w_hdr[8*(UDP_LEN_OFS+1) +: 8]};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_cnt <= '0;
            r_hdr <= '0;
        end else begin
            if (i_clear || w_done) begin
                r_cnt <= '0;
            end else if (i_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_beat) begin
                r_hdr <= w_hdr;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/udp_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : udp_rx_param                                                 |
// | Description : UDP receive de-encapsulator. Strips the 8-byte header,      |
// |               optionally filters on source/destination port, passes the   |
// |               payload through with zero latency and flags length or IP   |
// |               checksum errors on the last payload beat.                  |
// | Ports       : clk, nreset   - clock, synchronous active-low reset         |
// |               cancel_i      - abort current IP payload                     |
// |               valid_i, last_i, data_i, len_i - IP payload stream          |
// |               ip_cs_err_i   - IP checksum error, sampled on last beat     |
// |               valid_o, last_o, data_o, len_o - UDP payload stream         |
// |               err_o         - error qualifier on last payload beat        |
// |               cancel_o      - cancel after payload forwarding began       |
// |               drop_o        - one-cycle pulse, packet discarded           |
// |               src_port_o, dst_port_o - ports of the current packet        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module udp_rx_param
    import udp_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int LEN_W          = $clog2(DATA_W / 8),
    parameter int MATCH_SRC_PORT = 1,
    parameter int MATCH_DST_PORT = 1,
    parameter int PORT_W         = 16,
    parameter int SRC_PORT       = 18070,
    parameter int DST_PORT       = 18070
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              ip_cs_err_i,
    output logic              valid_o,
    output logic              last_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              err_o,
    output logic              cancel_o,
    output logic              drop_o,
    output logic [PORT_W-1:0] src_port_o,
    output logic [PORT_W-1:0] dst_port_o
);

    localparam logic [UDP_LEN_W-1:0] C_BPB      = UDP_LEN_W'(DATA_W / 8);
    localparam logic [UDP_LEN_W-1:0] C_HDR_LEN  = UDP_LEN_W'(UDP_HDR_BYTES);

    udp_rx_state_e          r_state;
    logic [UDP_LEN_W-1:0]   r_bytes;
    logic [UDP_LEN_W-1:0]   r_udp_len;
    logic [PORT_W-1:0]      r_src;
    logic [PORT_W-1:0]      r_dst;
    logic                   r_drop;

    logic                   w_in_hdr;
    logic                   w_hdr_beat;
    logic                   w_hdr_done;
    logic                   w_runt;
    logic                   w_port_ok;
    logic                   w_pl_beat;
    logic [UDP_PORT_W-1:0]  w_src;
    logic [UDP_PORT_W-1:0]  w_dst;
    logic [UDP_LEN_W-1:0]   w_udp_len;
    logic [UDP_LEN_W-1:0]   w_beat_bytes;
    logic [UDP_LEN_W-1:0]   w_count;
    logic                   w_len_err;

    assign w_in_hdr   = (r_state == ST_IDLE) || (r_state == ST_HDR);
    assign w_hdr_beat = valid_i && w_in_hdr && !cancel_i;
    // A last beat before the header is complete leaves nothing to deliver.
    assign w_runt     = w_hdr_beat && last_i && !w_hdr_done;

    udp_rx_hdr_capture #(
        .DATA_W (DATA_W)
    ) u_hdr (
        .clk        (clk),
        .nreset     (nreset),
        .i_beat     (w_hdr_beat),
        .i_clear    (cancel_i || w_runt),
        .i_data     (data_i),
        .o_hdr_done (w_hdr_done),
        .o_src_port (w_src),
        .o_dst_port (w_dst),
        .o_udp_len  (w_udp_len)
    );

    assign w_port_ok = ((MATCH_SRC_PORT == 0) || (w_src == UDP_PORT_W'(SRC_PORT))) &&
                       ((MATCH_DST_PORT == 0) || (w_dst == UDP_PORT_W'(DST_PORT)));

    // len_i == 0 on the last beat means a full beat.
    assign w_beat_bytes = (!last_i || (len_i == '0)) ? C_BPB : UDP_LEN_W'(len_i);
    assign w_count      = sat_add16(r_bytes, w_beat_bytes);
    assign w_len_err    = (w_count != (r_udp_len - C_HDR_LEN)) || (r_udp_len < C_HDR_LEN);

    assign w_pl_beat  = (r_state == ST_PLOAD) && valid_i && !cancel_i;
    assign valid_o    = w_pl_beat;
    assign last_o     = w_pl_beat && last_i;
    assign err_o      = w_pl_beat && last_i && (w_len_err || ip_cs_err_i);
    assign cancel_o   = cancel_i && (r_state == ST_PLOAD);
    assign data_o     = data_i;
    assign len_o      = len_i;
    assign drop_o     = r_drop;
    assign src_port_o = r_src;
    assign dst_port_o = r_dst;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state   <= ST_IDLE;
            r_bytes   <= '0;
            r_udp_len <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (cancel_i) begin
                r_state <= ST_IDLE;
            end else if (valid_i) begin
                case (r_state)
                    ST_IDLE, ST_HDR: begin
                        if (w_hdr_done) begin
                            if (!w_port_ok) begin
                                r_drop  <= 1'b1;
                                r_state <= last_i ? ST_IDLE : ST_DROP;
                            end else if (last_i) begin
                                // Header-only datagram: nothing to forward.
                                r_state <= ST_IDLE;
                            end else begin
                                r_state   <= ST_PLOAD;
                                r_bytes   <= '0;
                                r_udp_len <= w_udp_len;
                                r_src     <= PORT_W'(w_src);
                                r_dst     <= PORT_W'(w_dst);
                            end
                        end else if (last_i) begin
                            r_drop  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_HDR;
                        end
                    end
                    ST_PLOAD: begin
                        if (last_i) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_bytes <= w_count;
                        end
                    end
                    ST_DROP: begin
                        if (last_i) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FORMAL
    always_ff @(posedge clk) begin
        if (nreset) begin
            assert ($onehot(r_state));
            assert (!valid_o || (r_state == ST_PLOAD));
            assert (!$isunknown({valid_o, last_o, err_o}));
        end
    end
`endif

endmodule
`default_nettype wire
